pc_generator: RTL and testbench

PC_GENERATOR -- requirements
Module: pc_generator

---
 rtl/pc_generator.sv | 149 ++++++++++++++
 tb/tb_pc_generator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_generator.sv
// Program counter generator: boot/run/halt sequencing, trap entry/return,
// branch redirects with misalignment trapping, and accepted-fetch counting.
module pc_generator #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int              STEP         = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            pc_hold,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_req,
    input  logic            trap_ret,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            imem_ready,
    output logic [XLEN-1:0] address_bus_IR,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            misaligned_fault,
    output logic [XLEN-1:0] fetch_count,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] STEP_W = XLEN'(STEP);
    localparam logic [XLEN-1:0] ONE_W  = XLEN'(1);

    state_t          cur_state;
    state_t          next_state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] epc_d;
    logic [XLEN-1:0] cnt_q;
    logic [XLEN-1:0] cnt_d;
    logic            fault_q;
    logic            fault_d;
    logic            accept;
    logic            misaligned;

    assign pc_valid         = (cur_state == RUN);
    assign accept           = pc_valid & imem_ready;
    assign misaligned       = (redirect_target[1:0] != 2'b00);
    assign address_bus_IR   = pc_q;
    assign epc              = epc_q;
    assign fetch_count      = cnt_q;
    assign misaligned_fault = fault_q;
    assign state            = cur_state;

    // State register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_state <= BOOT;
        end else begin
            cur_state <= next_state;
        end
    end

    // Next-state logic: halt beats resume in RUN, trap wakes from HALTED
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            BOOT: begin
                next_state = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                if (trap_req || resume) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    // PC / EPC / fault update in priority order: trap, return, redirect, advance
    always_comb begin
        pc_d    = pc_q;
        epc_d   = epc_q;
        fault_d = 1'b0;
        case (cur_state)
            RUN: begin
                if (trap_req) begin
                    epc_d = pc_q;
                    pc_d  = TRAP_VECTOR;
                end else if (trap_ret) begin
                    pc_d = epc_q;
                end else if (redirect_valid) begin
                    if (misaligned) begin
                        epc_d   = pc_q;
                        pc_d    = TRAP_VECTOR;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = redirect_target;
                    end
                end else if (accept && !pc_hold) begin
                    pc_d = pc_q + STEP_W;
                end
            end
            HALTED: begin
                if (trap_req) begin
                    epc_d = pc_q;
                    pc_d  = TRAP_VECTOR;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // Fetch counter advances on every accepted fetch, wrapping naturally
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = cnt_q + ONE_W;
        end
    end

    // Datapath registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q    <= RESET_VECTOR;
            epc_q   <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

endmodule

// File: tb/tb_pc_generator.sv
// Testbench for pc_generator: directed vector table, a short hand sequence,
// and randomized traffic against a behavioural reference model.
module tb_pc_generator;

    logic        clock;
    logic        reset;
    logic        pc_hold;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_req;
    logic        trap_ret;
    logic        halt_req;
    logic        resume;
    logic        imem_ready;
    logic [31:0] address_bus_IR;
    logic        pc_valid;
    logic [31:0] epc;
    logic        misaligned_fault;
    logic [31:0] fetch_count;
    logic [1:0]  state;

    int n_cmp;
    int n_bad;

    pc_generator dut (
        .clock           (clock),
        .reset           (reset),
        .pc_hold         (pc_hold),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_req        (trap_req),
        .trap_ret        (trap_ret),
        .halt_req        (halt_req),
        .resume          (resume),
        .imem_ready      (imem_ready),
        .address_bus_IR  (address_bus_IR),
        .pc_valid        (pc_valid),
        .epc             (epc),
        .misaligned_fault(misaligned_fault),
        .fetch_count     (fetch_count),
        .state           (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        hold;
        logic        rv;
        logic [31:0] tgt;
        logic        tr;
        logic        tret;
        logic        halt;
        logic        res;
        logic        rdy;
        logic [31:0] e_pc;
        logic [31:0] e_epc;
        logic [1:0]  e_st;
        logic        e_f;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(
        logic rst, logic hold, logic rv, logic [31:0] tgt,
        logic tr, logic tret, logic halt, logic res, logic rdy,
        logic [31:0] e_pc, logic [31:0] e_epc, logic [1:0] e_st,
        logic e_f, logic [31:0] e_cnt);
        vec_t r;
        r.rst = rst; r.hold = hold; r.rv = rv; r.tgt = tgt;
        r.tr = tr; r.tret = tret; r.halt = halt; r.res = res; r.rdy = rdy;
        r.e_pc = e_pc; r.e_epc = e_epc; r.e_st = e_st;
        r.e_f = e_f; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        reset           = v.rst;
        pc_hold         = v.hold;
        redirect_valid  = v.rv;
        redirect_target = v.tgt;
        trap_req        = v.tr;
        trap_ret        = v.tret;
        halt_req        = v.halt;
        resume          = v.res;
        imem_ready      = v.rdy;
    endtask

    task automatic check_all(string tag, logic [31:0] pc, logic [31:0] ep,
                             logic [1:0] st, logic f, logic [31:0] cnt);
        chk({tag, ".pc"}, address_bus_IR, pc);
        chk({tag, ".epc"}, epc, ep);
        chk({tag, ".state"}, {30'd0, state}, {30'd0, st});
        chk({tag, ".fault"}, {31'd0, misaligned_fault}, {31'd0, f});
        chk({tag, ".count"}, fetch_count, cnt);
        chk({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, (st == 2'd1)});
    endtask

    // Behavioural reference model
    int unsigned  m_st;
    longint       m_pc;
    longint       m_epc;
    longint       m_cnt;
    logic         m_f;
    localparam longint MASK = 64'hFFFF_FFFF;

    task automatic model_step();
        if (!reset) begin
            m_st = 0; m_pc = 0; m_epc = 0; m_cnt = 0; m_f = 0;
            return;
        end
        m_f = 0;
        if (m_st == 0) begin
            m_st = 1;
        end else if (m_st == 1) begin
            if (imem_ready) m_cnt = (m_cnt + 1) & MASK;
            if (trap_req) begin
                m_epc = m_pc; m_pc = 'h100;
            end else if (trap_ret) begin
                m_pc = m_epc;
            end else if (redirect_valid) begin
                if (redirect_target % 4 != 0) begin
                    m_epc = m_pc; m_pc = 'h100; m_f = 1;
                end else begin
                    m_pc = longint'(redirect_target);
                end
            end else if (imem_ready && !pc_hold) begin
                m_pc = (m_pc + 4) & MASK;
            end
            if (halt_req) m_st = 2;
        end else begin
            if (trap_req) begin
                m_epc = m_pc; m_pc = 'h100; m_st = 1;
            end else if (resume) begin
                m_st = 1;
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0]  = mk(0,0,0,32'h0,0,0,0,0,1, 32'h0,32'h0,0,0,0);
        vecs[1]  = mk(1,0,0,32'h0,0,0,0,0,1, 32'h0,32'h0,1,0,0);
        vecs[2]  = mk(1,0,0,32'h0,0,0,0,0,1, 32'h4,32'h0,1,0,1);
        vecs[3]  = mk(1,0,0,32'h0,0,0,0,0,1, 32'h8,32'h0,1,0,2);
        vecs[4]  = mk(1,0,1,32'h10,0,0,0,0,1, 32'h10,32'h0,1,0,3);
        vecs[5]  = mk(1,1,1,32'h200,0,0,0,0,1, 32'h200,32'h0,1,0,4);
        vecs[6]  = mk(1,1,0,32'h0,0,0,0,0,1, 32'h200,32'h0,1,0,5);
        vecs[7]  = mk(1,0,0,32'h0,0,0,0,0,0, 32'h200,32'h0,1,0,5);
        vecs[8]  = mk(1,0,1,32'h24,0,0,0,0,0, 32'h24,32'h0,1,0,5);
        vecs[9]  = mk(1,0,1,32'h302,0,0,0,0,0, 32'h100,32'h24,1,1,5);
        vecs[10] = mk(1,0,0,32'h0,0,0,0,0,0, 32'h100,32'h24,1,0,5);
        vecs[11] = mk(1,0,1,32'h40,0,0,0,0,0, 32'h40,32'h24,1,0,5);
        vecs[12] = mk(1,0,1,32'h80,1,0,0,0,0, 32'h100,32'h40,1,0,5);
        vecs[13] = mk(1,0,0,32'h0,0,1,0,0,0, 32'h40,32'h40,1,0,5);
        vecs[14] = mk(1,0,1,32'hFFFF_FFFC,0,0,0,0,0, 32'hFFFF_FFFC,32'h40,1,0,5);
        vecs[15] = mk(1,0,0,32'h0,0,0,0,0,1, 32'h0,32'h40,1,0,6);
        vecs[16] = mk(1,0,0,32'h0,0,0,1,0,1, 32'h4,32'h40,2,0,7);
        vecs[17] = mk(1,1,1,32'h80,0,1,0,0,1, 32'h4,32'h40,2,0,7);
        vecs[18] = mk(1,0,0,32'h0,0,0,0,1,1, 32'h4,32'h40,1,0,7);
        vecs[19] = mk(1,0,0,32'h0,0,0,0,0,1, 32'h8,32'h40,1,0,8);
        vecs[20] = mk(1,0,0,32'h0,0,0,1,1,0, 32'h8,32'h40,2,0,8);
        vecs[21] = mk(1,0,0,32'h0,1,0,0,1,0, 32'h100,32'h8,1,0,8);
        vecs[22] = mk(1,0,1,32'h40,0,0,0,0,0, 32'h40,32'h8,1,0,8);
        vecs[23] = mk(1,0,0,32'h0,1,0,0,0,0, 32'h100,32'h40,1,0,8);
        vecs[24] = mk(1,0,0,32'h0,0,0,1,0,0, 32'h100,32'h40,2,0,8);
        vecs[25] = mk(0,0,0,32'h0,0,0,0,0,1, 32'h0,32'h0,0,0,0);
        vecs[26] = mk(1,0,0,32'h0,0,0,0,0,1, 32'h0,32'h0,1,0,0);

        drive(vecs[0]);
        @(negedge clock);
        for (int i = 0; i < 27; i++) begin
            drive(vecs[i]);
            @(posedge clock);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_epc,
                      vecs[i].e_st, vecs[i].e_f, vecs[i].e_cnt);
        end

        // Back-to-back misaligned redirects, then reset during a trap
        imem_ready = 0;
        redirect_valid = 1; redirect_target = 32'h8;
        @(posedge clock); #1;
        check_all("seq_al", 32'h8, 32'h0, 1, 0, 0);
        redirect_target = 32'h9;
        @(posedge clock); #1;
        check_all("seq_mis1", 32'h100, 32'h8, 1, 1, 0);
        redirect_target = 32'h103;
        @(posedge clock); #1;
        check_all("seq_mis2", 32'h100, 32'h100, 1, 1, 0);
        redirect_valid = 0;
        @(posedge clock); #1;
        check_all("seq_clr", 32'h100, 32'h100, 1, 0, 0);
        trap_req = 1; reset = 0;
        @(posedge clock); #1;
        check_all("seq_rst", 32'h0, 32'h0, 0, 0, 0);
        trap_req = 0;

        // Randomized traffic against the reference model
        model_step();
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 60) != 0);
            pc_hold         = ($urandom_range(0, 3) == 0);
            redirect_valid  = ($urandom_range(0, 5) == 0);
            redirect_target = $urandom;
            if ($urandom_range(0, 1) == 0) redirect_target[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) redirect_target[31:4] = 28'hFFF_FFFF;
            trap_req        = ($urandom_range(0, 15) == 0);
            trap_ret        = ($urandom_range(0, 11) == 0);
            halt_req        = ($urandom_range(0, 19) == 0);
            resume          = ($urandom_range(0, 4) == 0);
            imem_ready      = ($urandom_range(0, 3) != 0);
            model_step();
            @(posedge clock);
            #1;
            check_all($sformatf("rnd%0d", i), m_pc[31:0], m_epc[31:0],
                      m_st[1:0], m_f, m_cnt[31:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
